// File: rtl/fp_shift_sequencer.sv
// ============================================================================
// fp_shift_sequencer : align/normalize shift sequencing for the FP adder
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_shift_sequencer #(
  parameter int EXP_W      = 8,
  parameter int MANT_W     = 28,
  parameter int MAX_RSHIFT = 27
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic              add_done,
  input  logic [MANT_W-1:0] sum_mant,
  input  logic              sum_ovf,
  output logic              busy,
  output logic              swap,
  output logic              shift_right_en,
  output logic [EXP_W-1:0]  shift_right_bits,
  output logic              shift_left_en,
  output logic [EXP_W-1:0]  shift_left_bits,
  output logic              add_start,
  output logic [EXP_W-1:0]  exp_out,
  output logic              done,
  output logic              exp_overflow,
  output logic              exp_underflow,
  output logic              zero_result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_WAIT  = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [EXP_W-1:0] r_exp;

  logic             w_swap;
  logic [EXP_W-1:0] w_diff;
  logic [EXP_W-1:0] w_max;
  logic [EXP_W-1:0] w_align_bits;
  logic [MANT_W-3:0] w_mag;
  logic [EXP_W-1:0] w_lz;
  logic [EXP_W-1:0] w_exp_inc;
  logic             w_sat;

  // Leading zeros of the magnitude field; the highest set bit wins.
  function automatic logic [EXP_W-1:0] f_lz(input logic [MANT_W-3:0] m);
    logic [EXP_W-1:0] n;
    n = EXP_W'(MANT_W - 2);
    for (int i = 0; i < MANT_W - 2; i++) begin
      if (m[i]) n = EXP_W'(MANT_W - 3 - i);
    end
    return n;
  endfunction

  assign w_swap       = (exp_b > exp_a);
  assign w_diff       = w_swap ? (exp_b - exp_a) : (exp_a - exp_b);
  assign w_max        = w_swap ? exp_b : exp_a;
  assign w_align_bits = (w_diff > EXP_W'(MAX_RSHIFT)) ? EXP_W'(MAX_RSHIFT) : w_diff;
  assign w_mag        = sum_mant[MANT_W-2:1];
  assign w_lz         = f_lz(w_mag);
  assign w_exp_inc    = r_exp + 1'b1;
  // Incremented exponent reaching all-ones, or wrapping past it, saturates.
  assign w_sat        = (&w_exp_inc) || (w_exp_inc == '0);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state          <= S_IDLE;
      r_exp            <= '0;
      busy             <= 1'b0;
      swap             <= 1'b0;
      shift_right_en   <= 1'b0;
      shift_right_bits <= '0;
      shift_left_en    <= 1'b0;
      shift_left_bits  <= '0;
      add_start        <= 1'b0;
      exp_out          <= '0;
      done             <= 1'b0;
      exp_overflow     <= 1'b0;
      exp_underflow    <= 1'b0;
      zero_result      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state          <= S_ALIGN;
            busy             <= 1'b1;
            swap             <= w_swap;
            r_exp            <= w_max;
            shift_right_en   <= 1'b1;
            shift_right_bits <= w_align_bits;
            exp_overflow     <= 1'b0;
            exp_underflow    <= 1'b0;
            zero_result      <= 1'b0;
          end
        end
        S_ALIGN: begin
          r_state          <= S_ADD;
          shift_right_en   <= 1'b0;
          shift_right_bits <= '0;
          add_start        <= 1'b1;
        end
        S_ADD: begin
          r_state   <= S_WAIT;
          add_start <= 1'b0;
        end
        S_WAIT: begin
          if (add_done) begin
            if (sum_ovf) begin
              r_state          <= S_NORM;
              shift_right_en   <= 1'b1;
              shift_right_bits <= EXP_W'(1);
              exp_out          <= w_sat ? '1 : w_exp_inc;
              exp_overflow     <= w_sat;
            end else if (w_mag == '0) begin
              r_state     <= S_DONE;
              zero_result <= 1'b1;
              exp_out     <= '0;
              done        <= 1'b1;
            end else begin
              r_state         <= S_NORM;
              shift_left_en   <= 1'b1;
              shift_left_bits <= w_lz;
              if (w_lz >= r_exp) begin
                exp_out       <= '0;
                exp_underflow <= 1'b1;
              end else begin
                exp_out <= r_exp - w_lz;
              end
            end
          end
        end
        S_NORM: begin
          r_state          <= S_DONE;
          shift_right_en   <= 1'b0;
          shift_right_bits <= '0;
          shift_left_en    <= 1'b0;
          shift_left_bits  <= '0;
          done             <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_shift_sequencer.sv
// ============================================================================
// tb_fp_shift_sequencer : directed self-checking bench for fp_shift_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fp_shift_sequencer;

  localparam int NCYC = 14;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic [7:0]  exp_a, exp_b;
  logic        add_done;
  logic [27:0] sum_mant;
  logic        sum_ovf;
  logic        busy, swap, shift_right_en, shift_left_en, add_start, done;
  logic [7:0]  shift_right_bits, shift_left_bits, exp_out;
  logic        exp_overflow, exp_underflow, zero_result;

  int checks   = 0;
  int failures = 0;
  int both_hi  = 0;

  logic       obs_re[NCYC], obs_le[NCYC], obs_as[NCYC], obs_dn[NCYC], obs_bs[NCYC];
  logic       obs_sw[NCYC], obs_ov[NCYC], obs_un[NCYC], obs_z[NCYC];
  logic [7:0] obs_rb[NCYC], obs_lb[NCYC], obs_eo[NCYC];

  fp_shift_sequencer dut (
    .clk(clk), .res(res), .start(start), .exp_a(exp_a), .exp_b(exp_b),
    .add_done(add_done), .sum_mant(sum_mant), .sum_ovf(sum_ovf),
    .busy(busy), .swap(swap),
    .shift_right_en(shift_right_en), .shift_right_bits(shift_right_bits),
    .shift_left_en(shift_left_en), .shift_left_bits(shift_left_bits),
    .add_start(add_start), .exp_out(exp_out), .done(done),
    .exp_overflow(exp_overflow), .exp_underflow(exp_underflow),
    .zero_result(zero_result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (shift_right_en && shift_left_en) both_hi++;

  // Runs one operation; add_done pulses in cycle 2+lat, an extra start in cycle extra_start.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat,
                        input logic [27:0] mant, input logic ovf, input int extra_start);
    for (int k = 0; k < NCYC; k++) begin
      obs_re[k] = 0; obs_le[k] = 0; obs_as[k] = 0; obs_dn[k] = 0; obs_bs[k] = 0;
      obs_sw[k] = 0; obs_ov[k] = 0; obs_un[k] = 0; obs_z[k] = 0;
      obs_rb[k] = 0; obs_lb[k] = 0; obs_eo[k] = 0;
    end
    @(negedge clk);
    exp_a = a; exp_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < NCYC; k++) begin
      @(negedge clk);
      obs_re[k] = shift_right_en; obs_rb[k] = shift_right_bits;
      obs_le[k] = shift_left_en;  obs_lb[k] = shift_left_bits;
      obs_as[k] = add_start; obs_dn[k] = done; obs_bs[k] = busy; obs_sw[k] = swap;
      obs_eo[k] = exp_out; obs_ov[k] = exp_overflow; obs_un[k] = exp_underflow;
      obs_z[k]  = zero_result;
      add_done = (k == 2 + lat);
      sum_mant = (k == 2 + lat) ? mant : 28'h0;
      sum_ovf  = (k == 2 + lat) ? ovf : 1'b0;
      start    = (k == extra_start);
      if (k == extra_start) begin exp_a = 8'h11; exp_b = 8'h77; end
      @(posedge clk); #1;
    end
    add_done = 0; sum_mant = 0; sum_ovf = 0; start = 0;
  endtask

  function automatic int first_done();
    for (int k = 1; k < NCYC; k++) if (obs_dn[k]) return k;
    return -1;
  endfunction

  function automatic int count_dn();
    int n = 0;
    for (int k = 1; k < NCYC; k++) if (obs_dn[k]) n++;
    return n;
  endfunction

  function automatic int count_re();
    int n = 0;
    for (int k = 1; k < NCYC; k++) if (obs_re[k]) n++;
    return n;
  endfunction

  function automatic int count_le();
    int n = 0;
    for (int k = 1; k < NCYC; k++) if (obs_le[k]) n++;
    return n;
  endfunction

  task automatic test_reset();
    res = 1'b1; start = 0; exp_a = 0; exp_b = 0; add_done = 0; sum_mant = 0; sum_ovf = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({shift_right_en, shift_left_en, add_start, done, swap} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {shift_right_en, shift_left_en, add_start, done, swap}); end
    checks++; if ({shift_right_bits, shift_left_bits, exp_out} !== 24'h0) begin
      failures++; $display("FAIL reset_buses got=%h exp=000000", {shift_right_bits, shift_left_bits, exp_out}); end
    checks++; if ({exp_overflow, exp_underflow, zero_result} !== 3'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {exp_overflow, exp_underflow, zero_result}); end
  endtask

  task automatic test_basic();
    run_op(8'h85, 8'h82, 1, 28'h4000001, 1'b0, 0);
    checks++; if (obs_sw[1] !== 1'b0) begin failures++; $display("FAIL basic_swap got=%b exp=0", obs_sw[1]); end
    checks++; if ({obs_re[1], obs_rb[1]} !== {1'b1, 8'd3}) begin
      failures++; $display("FAIL basic_align got=%b/%0d exp=1/3", obs_re[1], obs_rb[1]); end
    checks++; if ({obs_re[2], obs_rb[2]} !== 9'h0) begin
      failures++; $display("FAIL basic_rbus_idle got=%b/%0d exp=0/0", obs_re[2], obs_rb[2]); end
    checks++; if (obs_as[2] !== 1'b1) begin failures++; $display("FAIL basic_add_start got=%b exp=1", obs_as[2]); end
    checks++; if ({obs_le[4], obs_lb[4]} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL basic_norm got=%b/%0d exp=1/0", obs_le[4], obs_lb[4]); end
    checks++; if (first_done() !== 5) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=5", first_done()); end
    checks++; if (obs_eo[5] !== 8'h85) begin failures++; $display("FAIL basic_exp_out got=%h exp=85", obs_eo[5]); end
    checks++; if ({obs_bs[1], obs_bs[5], obs_bs[6]} !== 3'b110) begin
      failures++; $display("FAIL basic_busy got=%b exp=110", {obs_bs[1], obs_bs[5], obs_bs[6]}); end
    checks++; if ({obs_ov[5], obs_un[5], obs_z[5]} !== 3'b000) begin
      failures++; $display("FAIL basic_flags got=%b exp=000", {obs_ov[5], obs_un[5], obs_z[5]}); end
  endtask

  task automatic test_swap_saturate();
    run_op(8'h10, 8'h40, 1, 28'h4000001, 1'b0, 0);
    checks++; if (obs_sw[1] !== 1'b1) begin failures++; $display("FAIL swap_flag got=%b exp=1", obs_sw[1]); end
    checks++; if (obs_rb[1] !== 8'd27) begin failures++; $display("FAIL swap_sat_bits got=%0d exp=27", obs_rb[1]); end
    checks++; if (obs_eo[5] !== 8'h40) begin failures++; $display("FAIL swap_exp_out got=%h exp=40", obs_eo[5]); end
  endtask

  task automatic test_normalize();
    run_op(8'h85, 8'h85, 1, 28'h0200001, 1'b0, 0);
    checks++; if ({obs_re[1], obs_rb[1], obs_sw[1]} !== {1'b1, 8'd0, 1'b0}) begin
      failures++; $display("FAIL norm_eq_align got=%b/%0d/%b exp=1/0/0", obs_re[1], obs_rb[1], obs_sw[1]); end
    checks++; if ({obs_le[4], obs_lb[4]} !== {1'b1, 8'd5}) begin
      failures++; $display("FAIL norm_lz got=%b/%0d exp=1/5", obs_le[4], obs_lb[4]); end
    checks++; if (obs_eo[5] !== 8'h80) begin failures++; $display("FAIL norm_exp_out got=%h exp=80", obs_eo[5]); end
  endtask

  task automatic test_overflow();
    run_op(8'hFE, 8'hFE, 1, 28'hC000001, 1'b1, 0);
    checks++; if ({obs_re[4], obs_rb[4], obs_le[4]} !== {1'b1, 8'd1, 1'b0}) begin
      failures++; $display("FAIL ovf_norm got=%b/%0d/%b exp=1/1/0", obs_re[4], obs_rb[4], obs_le[4]); end
    checks++; if (obs_eo[5] !== 8'hFF) begin failures++; $display("FAIL ovf_exp_out got=%h exp=ff", obs_eo[5]); end
    checks++; if (obs_ov[5] !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", obs_ov[5]); end
  endtask

  task automatic test_underflow();
    run_op(8'h03, 8'h01, 1, 28'h0200001, 1'b0, 0);
    checks++; if ({obs_le[4], obs_lb[4]} !== {1'b1, 8'd5}) begin
      failures++; $display("FAIL unf_shift got=%b/%0d exp=1/5", obs_le[4], obs_lb[4]); end
    checks++; if ({obs_eo[5], obs_un[5]} !== {8'h00, 1'b1}) begin
      failures++; $display("FAIL unf_result got=%h/%b exp=00/1", obs_eo[5], obs_un[5]); end
  endtask

  task automatic test_zero();
    run_op(8'h20, 8'h22, 1, 28'h8000001, 1'b0, 0);
    checks++; if (first_done() !== 4) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=4", first_done()); end
    checks++; if ({count_le(), count_re()} !== {32'd0, 32'd1}) begin
      failures++; $display("FAIL zero_no_norm got=left%0d/right%0d exp=left0/right1", count_le(), count_re()); end
    checks++; if ({obs_z[4], obs_eo[4]} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL zero_result got=%b/%h exp=1/00", obs_z[4], obs_eo[4]); end
  endtask

  task automatic test_delay();
    run_op(8'h50, 8'h4F, 4, 28'h4000001, 1'b0, 0);
    checks++; if (first_done() !== 8) begin failures++; $display("FAIL delay_done_cycle got=%0d exp=8", first_done()); end
    checks++; if ({obs_re[3], obs_re[4], obs_re[5], obs_re[6], obs_le[3], obs_le[4], obs_le[5], obs_le[6]} !== 8'h0) begin
      failures++; $display("FAIL delay_wait_quiet got=enable pulse in WAIT exp=none"); end
    checks++; if ({obs_le[7], obs_eo[8]} !== {1'b1, 8'h50}) begin
      failures++; $display("FAIL delay_norm got=%b/%h exp=1/50", obs_le[7], obs_eo[8]); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    // Abort in WAIT after a completed operation left exp_out nonzero.
    run_op(8'h85, 8'h82, 1, 28'h4000001, 1'b0, 0);
    @(negedge clk);
    exp_a = 8'h30; exp_b = 8'h31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
    #2 res = 1'b1;
    #1;
    checks++; if ({busy, exp_out, swap, done} !== 11'h0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%h/%b/%b exp=0/00/0/0", busy, exp_out, swap, done); end
    @(negedge clk);
    res = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      add_done = (k == 1);
      @(negedge clk);
      if (done) ndone++;
    end
    add_done = 1'b0;
    checks++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    // Abort in ALIGN: the right enable must fall with the reset.
    @(negedge clk);
    exp_a = 8'h40; exp_b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #2 res = 1'b1;
    #1;
    checks++; if ({shift_right_en, shift_right_bits} !== 9'h0) begin
      failures++; $display("FAIL rstalign_enable got=%b/%0d exp=0/0", shift_right_en, shift_right_bits); end
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(8'h85, 8'h82, 1, 28'h4000001, 1'b0, 2);
    checks++; if ({count_dn(), first_done()} !== {32'd1, 32'd5}) begin
      failures++; $display("FAIL busy_start_done got=count%0d/cycle%0d exp=count1/cycle5", count_dn(), first_done()); end
    checks++; if ({count_re(), obs_sw[5], obs_eo[5]} !== {32'd1, 1'b0, 8'h85}) begin
      failures++; $display("FAIL busy_start_ignored got=re%0d/%b/%h exp=re1/0/85", count_re(), obs_sw[5], obs_eo[5]); end
    run_op(8'h85, 8'h82, 1, 28'h4000001, 1'b0, 5);
    checks++; if ({count_re(), count_dn(), obs_bs[6]} !== {32'd1, 32'd1, 1'b0}) begin
      failures++; $display("FAIL done_start_ignored got=re%0d/dn%0d/busy%b exp=re1/dn1/busy0", count_re(), count_dn(), obs_bs[6]); end
    run_op(8'h01, 8'h02, 1, 28'h4000001, 1'b0, 0);
    checks++; if ({first_done(), obs_sw[1], obs_rb[1]} !== {32'd5, 1'b1, 8'd1}) begin
      failures++; $display("FAIL back_to_back got=cycle%0d/%b/%0d exp=cycle5/1/1", first_done(), obs_sw[1], obs_rb[1]); end
    checks++; if (both_hi !== 0) begin failures++; $display("FAIL enable_exclusion got=%0d exp=0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap_saturate();
    test_normalize();
    test_overflow();
    test_underflow();
    test_zero();
    test_delay();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_shift_sequencer.md
Name: fp_shift_sequencer

Overview:
- Control FSM for the floating-point adder's shared 28-bit mantissa shifter.
- Per operation, uses the shifter twice: once to right-shift the smaller operand for exponent alignment, and once after the add to normalize the sum (left shift, or right shift by 1 on carry-out).
- Tracks the result exponent, flags exponent overflow, underflow and zero, and presents a start/busy/done handshake to the top-level adder.
- The shifter is registered (output valid the cycle after an enable pulse), and its mantissa format is: bit 27 sign, bits 26:1 magnitude, bit 0 forced mark.

Parameters:
EXP_W, 8, exponent width; also the width of the shift-amount buses
MANT_W, 28, mantissa bus width: sign bit, magnitude bits MANT_W-2 down to 1, mark bit 0
MAX_RSHIFT, 27, saturation limit for the alignment shift amount

Ports:
clk  input  1  system clock, rising-edge
res  input  1  asynchronous active-high reset
start  input  1  one-cycle request; accepted only when busy=0
exp_a  input  EXP_W  exponent of operand A, sampled with start
exp_b  input  EXP_W  exponent of operand B, sampled with start
add_done  input  1  adder result valid (single-cycle pulse)
sum_mant  input  MANT_W  adder mantissa result, sampled with add_done
sum_ovf  input  1  adder magnitude carry-out, sampled with add_done
busy  output  1  high from the cycle after start is accepted until done
swap  output  1  1 = operand B has the larger exponent; steers the operand muxes
shift_right_en  output  1  shifter right-shift enable
shift_right_bits  output  EXP_W  right-shift amount
shift_left_en  output  1  shifter left-shift enable
shift_left_bits  output  EXP_W  left-shift amount
add_start  output  1  one-cycle pulse that launches the adder
exp_out  output  EXP_W  result exponent; valid while done=1 and held until the next start
done  output  1  one-cycle completion pulse
exp_overflow  output  1  result exponent saturated at all-ones
exp_underflow  output  1  normalization needed more shift than the exponent allows
zero_result  output  1  magnitude of the sum is zero

Behaviour:
- Reset (asynchronous, res=1): state IDLE. All outputs 0, including exp_out and the flags. Internal registers cleared.
- Reset mid-operation: abort immediately to IDLE. No done pulse. The shifter enables drop in the same reset assertion.
- Mutual exclusion: shift_right_en and shift_left_en are never high in the same cycle. Each enable is a single-cycle pulse.
- When an enable is low, its shift-amount bus holds 0.
- States: IDLE -> ALIGN -> ADD -> WAIT -> NORM -> DONE -> IDLE.
- IDLE:
  - On start: latch exp_a and exp_b.
  - swap = (exp_b > exp_a); when exponents are equal, swap=0.
  - diff = |exp_a - exp_b|; exp_r = max(exp_a, exp_b).
  - Clear the flags. Go to ALIGN.
  - start while busy=1 is ignored.
- ALIGN (1 cycle): shift_right_en=1, shift_right_bits = min(diff, MAX_RSHIFT). Asserted even when diff=0 (shift of 0).
- ADD (1 cycle): add_start=1.
- WAIT: hold until add_done. No timeout.
  - On add_done, capture sum_mant and sum_ovf, then compute:
  - If sum_ovf=1: plan a right shift of 1, exp_r+1. If exp_r+1 overflows to all-ones, saturate exp_out to all-ones and set exp_overflow=1.
  - Else if sum_mant[MANT_W-2:1]==0: zero_result=1, exp_out=0, skip NORM.
  - Else: lz = leading zeros of sum_mant[MANT_W-2:1] (range 0..MANT_W-3).
    - If lz >= exp_r: exp_out=0, exp_underflow=1, shift amount still lz.
    - Else exp_out = exp_r - lz.
- NORM (1 cycle):
  - On overflow: shift_right_en=1 with bits=1.
  - Otherwise: shift_left_en=1 with bits=lz. lz=0 still pulses with bits 0.
- DONE (1 cycle): done=1, busy drops to 0 on the following edge. Return to IDLE.
- A start arriving in the DONE cycle is ignored; it is accepted from IDLE only.
- Latency with add_done on the first WAIT cycle: start sampled at edge 0; ALIGN in cycle 1, ADD 2, WAIT 3, NORM 4, DONE 5.
- Zero-result path: DONE in cycle 4.
- Each extra cycle of adder latency adds one cycle to the total.
- exp_out and the flags update when NORM is entered (or DONE, on the zero path) and are stable through DONE.

Test Plan:
- exp_a=0x85, exp_b=0x82, add_done one cycle after add_start, sum_mant bit26=1, sum_ovf=0 -> swap=0; right pulse bits=3 in cycle 1; left pulse bits=0; exp_out=0x85; done in cycle 5.
- exp_a=0x10, exp_b=0x40 -> swap=1, shift_right_bits=27 (saturated from 0x30).
- sum_ovf=1 with exp_a=exp_b=0xFE -> NORM right pulse bits=1, exp_out=0xFF, exp_overflow=1.
- exp_r=0x03, sum_mant magnitude with lz=5 -> shift_left_bits=5, exp_out=0, exp_underflow=1; sum magnitude 0 -> zero_result=1, no NORM pulse, done in cycle 4.
- res asserted during WAIT, then a second start during busy -> outputs 0 immediately, no done; a start while busy produces no extra operation and no second done.
- add_done delayed 4 cycles -> FSM holds in WAIT, done in cycle 8; the enables are never both high in any cycle.
